loby_stream: RTL and testbench
==============================

# loby_stream

Parametrised, handshaked successor to the LoBy core. It holds a STATE_W-bit keyed sponge state. It accepts init, absorb and squeeze commands over a valid/ready input channel and iterates a configurable number of permutation rounds, one per cycle. It presents squeezed state on a valid/ready output channel that supports back-pressure. It sits between a host/DMA command stream and downstream consumers, replacing the fixed-timing init/sqz/din_valid strobes.

## Interface
- STATE_W, 257: state and key width
- RATE, 64: absorbed block width; 1 ≤ RATE ≤ STATE_W
- ROUNDS, 1: permutation rounds per absorb/squeeze; ≥ 1
- clk  in  1  clock, rising edge
- arstn  in  1  asynchronous active-low reset
- key  in  STATE_W  key, sampled on accepted init
- in_valid  in  1  command valid
- in_ready  out  1  command ready
- cmd  in  2  00 absorb, 01 squeeze, 10 init, 11 reserved
- din  in  RATE  data block for absorb/squeeze
- dout_valid  out  1  squeeze result valid
- dout_ready  in  1  consumer ready
- dout  out  STATE_W  squeeze result
- busy  out  1  FSM not in IDLE
- err  out  1  sticky command error

## Operation
- FSM states: IDLE, PERMUTE, OUT.
- Accept condition: in_valid & in_ready. in_ready = (state == IDLE).
- init: state ← key; keyed ← 1; err ← 0. FSM stays in IDLE.
- absorb/squeeze with keyed = 1:
  - state[RATE-1:0] ^= din.
  - round counter ← 0; FSM → PERMUTE.
- PERMUTE, each cycle: state ← loby_round(state, rnd); rnd++.
  - After round ROUNDS-1: absorb → IDLE.
  - After round ROUNDS-1: squeeze → OUT, with dout ← final state.
- OUT: dout_valid = 1. dout is held stable until dout_ready; on the handshake the FSM goes to IDLE.
- dout keeps its last value after the handshake until the next squeeze.
- absorb/squeeze with keyed = 0: command is consumed; err ← 1; state unchanged.
- cmd 11: command is consumed; err ← 1; no state change.
- Round counter width is $clog2(ROUNDS+1). It wraps to 0 on every new command.

## Timing
- Reset values: state 0, keyed 0, FSM IDLE, in_ready 1, dout_valid 0, dout 0, busy 0, err 0.
- init: in_ready stays high; the next command can be accepted on the following cycle.
- absorb: in_ready is low for ROUNDS cycles after the accept edge.
- squeeze: dout_valid rises ROUNDS cycles after the accept edge (registered).
- dout_valid and busy are registered. in_ready is combinational from the FSM state only, never from in_valid.
- OUT with dout_ready already high: one-cycle pulse; IDLE on the next cycle.
- OUT with dout_ready low: hold indefinitely. No new command is accepted.
- arstn asserted in any state, including mid-PERMUTE or OUT: all outputs go to reset values immediately. The in-flight command is lost.

## Configuration
- LOBY_STREAM_KEYFEED_EN defined: on the last PERMUTE cycle of a squeeze, dout ← state_next ^ key_reg and state ← state_next ^ key_reg. key_reg is captured at init. Squeeze latency is unchanged.
- Not defined: no key feed-forward; key_reg is not instantiated.

## Structure
- Package loby_pkg holds:
  - the cmd typedef (CMD_ABSORB, CMD_SQUEEZE, CMD_INIT, CMD_RSVD)
  - the FSM state typedef
  - the STATE_W and RATE defaults
  - the round-constant function indexed by rnd
- Sub-module loby_round: combinational single round (state, rnd) → state. The bench's golden model shares the same round definition.

## Test plan
- Reset release → in_ready = 1, dout_valid = 0, dout = 0, err = 0, busy = 0.
- ROUNDS = 1:
  - Stimulus: init key = {256'b0, 1'b1}, then squeeze with din = 64'h0000_0000_0000_0001 and dout_ready = 1.
  - Required: dout_valid high exactly 1 cycle after accept; dout = golden model; in_ready back high 2 cycles after accept.
- Back-pressure: dout_ready = 0 for 10 cycles in OUT → dout stable, in_ready = 0, busy = 1. Raising dout_ready → dout_valid = 0 and in_ready = 1 on the next cycle.
- Error handling:
  - absorb before any init → err = 1, state still 0.
  - cmd 11 → err = 1, busy stays 0.
  - Subsequent init → err = 0.
- ROUNDS = 3, vector file sequence init/absorb/absorb/squeeze/squeeze → final dout matches file. Each absorb holds in_ready low 3 cycles.
- arstn pulsed in the 2nd PERMUTE cycle (ROUNDS = 3) → outputs return to reset values immediately. After release, an absorb gives err = 1 (keyed cleared).

Source files
------------

// File: rtl/loby_pkg.sv
// Shared types, default widths and the round-constant schedule for the LoBy stream core.
package loby_pkg;

    localparam int LOBY_STATE_W = 257;
    localparam int LOBY_RATE    = 64;

    localparam logic [63:0] LOBY_RC_BASE = 64'h9E37_79B9_7F4A_7C15;

    typedef enum logic [1:0] {
        CMD_ABSORB  = 2'b00,
        CMD_SQUEEZE = 2'b01,
        CMD_INIT    = 2'b10,
        CMD_RSVD    = 2'b11
    } loby_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PERMUTE = 2'd1,
        ST_OUT     = 2'd2
    } loby_state_e;

    // Round r injects (r+1) multiples of the golden-ratio constant into the low word.
    function automatic logic [63:0] loby_rc(input logic [31:0] rnd);
        return LOBY_RC_BASE * ({32'd0, rnd} + 64'd1);
    endfunction

endpackage

// File: rtl/loby_round.sv
// One combinational LoBy round: chi-style nonlinear mix, rotate by 7, add round constant.
module loby_round
    import loby_pkg::*;
#(
    parameter int STATE_W = LOBY_STATE_W,
    parameter int RND_W   = 1
) (
    input  logic [STATE_W-1:0] state_i,
    input  logic [RND_W-1:0]   rnd_i,
    output logic [STATE_W-1:0] state_o
);

    localparam int ROT_A = 1 % STATE_W;
    localparam int ROT_B = 2 % STATE_W;
    localparam int ROT_C = 7 % STATE_W;

    function automatic logic [STATE_W-1:0] rotl(input logic [STATE_W-1:0] x, input int k);
        return (x << k) | (x >> (STATE_W - k));
    endfunction

    logic [STATE_W-1:0] chi;

    assign chi     = state_i ^ (~rotl(state_i, ROT_A) & rotl(state_i, ROT_B));
    assign state_o = rotl(chi, ROT_C) ^ STATE_W'(loby_rc(32'(rnd_i)));

endmodule

// File: rtl/loby_stream.sv
// Handshaked keyed sponge: init/absorb/squeeze commands in, squeezed state out with back-pressure.
// Optional feature: define LOBY_STREAM_KEYFEED_EN to xor the init key into the squeeze result.
module loby_stream
    import loby_pkg::*;
#(
    parameter int STATE_W = LOBY_STATE_W,
    parameter int RATE    = LOBY_RATE,
    parameter int ROUNDS  = 1
) (
    input  logic               clk,
    input  logic               arstn,
    input  logic [STATE_W-1:0] key,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         cmd,
    input  logic [RATE-1:0]    din,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [STATE_W-1:0] dout,
    output logic               busy,
    output logic               err
);

    localparam int               RND_W    = $clog2(ROUNDS + 1);
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);

    loby_state_e        fsm_q, fsm_d;
    loby_cmd_e          cmd_e;
    logic [STATE_W-1:0] state_q, state_d, state_nx, sqz_out;
    logic [STATE_W-1:0] dout_q, dout_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    logic               keyed_q, keyed_d;
    logic               sqz_q, sqz_d;
    logic               err_q, err_d;
    logic               dout_valid_q, busy_q;

    assign cmd_e = loby_cmd_e'(cmd);

    loby_round #(
        .STATE_W (STATE_W),
        .RND_W   (RND_W)
    ) u_round (
        .state_i (state_q),
        .rnd_i   (rnd_q),
        .state_o (state_nx)
    );

`ifdef LOBY_STREAM_KEYFEED_EN
    logic [STATE_W-1:0] key_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            key_q <= '0;
        end else if (in_valid && in_ready && cmd_e == CMD_INIT) begin
            key_q <= key;
        end
    end

    assign sqz_out = state_nx ^ key_q;
`else
    assign sqz_out = state_nx;
`endif

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        keyed_d = keyed_q;
        sqz_d   = sqz_q;
        rnd_d   = rnd_q;
        err_d   = err_q;
        dout_d  = dout_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    case (cmd_e)
                        CMD_INIT: begin
                            state_d = key;
                            keyed_d = 1'b1;
                            err_d   = 1'b0;
                        end
                        CMD_ABSORB, CMD_SQUEEZE: begin
                            // Unkeyed data commands are swallowed and only flag the error.
                            if (keyed_q) begin
                                state_d[RATE-1:0] = state_q[RATE-1:0] ^ din;
                                rnd_d             = '0;
                                sqz_d             = (cmd_e == CMD_SQUEEZE);
                                fsm_d             = ST_PERMUTE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_PERMUTE: begin
                state_d = state_nx;
                rnd_d   = rnd_q + RND_W'(1);
                if (rnd_q == RND_LAST) begin
                    if (sqz_q) begin
                        state_d = sqz_out;
                        dout_d  = sqz_out;
                        fsm_d   = ST_OUT;
                    end else begin
                        fsm_d = ST_IDLE;
                    end
                end
            end
            ST_OUT: begin
                if (dout_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            fsm_q        <= ST_IDLE;
            state_q      <= '0;
            dout_q       <= '0;
            rnd_q        <= '0;
            keyed_q      <= 1'b0;
            sqz_q        <= 1'b0;
            err_q        <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            state_q      <= state_d;
            dout_q       <= dout_d;
            rnd_q        <= rnd_d;
            keyed_q      <= keyed_d;
            sqz_q        <= sqz_d;
            err_q        <= err_d;
            dout_valid_q <= (fsm_d == ST_OUT);
            busy_q       <= (fsm_d != ST_IDLE);
        end
    end

    assign in_ready   = (fsm_q == ST_IDLE);
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign dout       = dout_q;
    assign err        = err_q;

endmodule

// File: tb/tb_loby_stream.sv
// Bench for loby_stream: ROUNDS=1 and ROUNDS=3 instances against a bit-level behavioural model.
module tb_loby_stream;
    import loby_pkg::*;

    localparam int SW = 257;
    localparam int RT = 64;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    logic [SW-1:0] key3, dout3, key1, dout1;
    logic [RT-1:0] din3, din1;
    logic [1:0]    cmd3, cmd1;
    logic iv3, ir3, dv3, dr3, busy3, err3;
    logic iv1, ir1, dv1, dr1, busy1, err1;

    loby_stream #(.STATE_W(SW), .RATE(RT), .ROUNDS(3)) u_r3 (
        .clk(clk), .arstn(arstn), .key(key3), .in_valid(iv3), .in_ready(ir3),
        .cmd(cmd3), .din(din3), .dout_valid(dv3), .dout_ready(dr3), .dout(dout3),
        .busy(busy3), .err(err3));

    loby_stream #(.STATE_W(SW), .RATE(RT), .ROUNDS(1)) u_r1 (
        .clk(clk), .arstn(arstn), .key(key1), .in_valid(iv1), .in_ready(ir1),
        .cmd(cmd1), .din(din1), .dout_valid(dv1), .dout_ready(dr1), .dout(dout1),
        .busy(busy1), .err(err1));

    int nchk = 0;
    int nerr = 0;

    // Behavioural model of the ROUNDS=3 instance
    logic [SW-1:0] m_st, m_key, m_dout;
    logic          m_keyed, m_err;

    typedef struct {
        string      nm;
        logic [1:0] cmd;
        logic       exp_err;
        logic       exp_busy;
    } vec_t;
    vec_t tbl[7];

    task automatic chkw(input string nm, input logic [SW-1:0] a, input logic [SW-1:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
    endtask

    task automatic chki(input string nm, input int a, input int e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s actual=%0d required=%0d", nm, a, e);
        end
    endtask

    function automatic logic [SW-1:0] rand_w();
        logic [SW-1:0] v = '0;
        for (int i = 0; i < 9; i++) v = (v << 32) | SW'($urandom);
        return v;
    endfunction

    // Round from its definition: bit i mixes with bits i-1 and i-2, whole word rotates
    // left by 7, low word receives (r+1) added copies of the golden-ratio constant.
    function automatic logic [SW-1:0] m_round(input logic [SW-1:0] s, input int r);
        logic [SW-1:0] t, o;
        logic [63:0]   c;
        for (int i = 0; i < SW; i++)
            t[i] = s[i] ^ (~s[(i + SW - 1) % SW] & s[(i + SW - 2) % SW]);
        for (int i = 0; i < SW; i++)
            o[(i + 7) % SW] = t[i];
        c = '0;
        for (int k = 0; k <= r; k++) c = c + 64'h9E37_79B9_7F4A_7C15;
        o[63:0] = o[63:0] ^ c;
        return o;
    endfunction

    function automatic logic [SW-1:0] m_perm(input logic [SW-1:0] s, input int n);
        for (int r = 0; r < n; r++) s = m_round(s, r);
        return s;
    endfunction

    task automatic model_reset();
        m_st = '0; m_key = '0; m_dout = '0; m_keyed = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_cmd(input logic [1:0] c, input logic [RT-1:0] d, input logic [SW-1:0] k);
        logic [SW-1:0] s;
        if (c == 2'b10) begin
            m_st = k; m_key = k; m_keyed = 1'b1; m_err = 1'b0;
        end else if (c == 2'b11 || !m_keyed) begin
            m_err = 1'b1;
        end else begin
            s = m_perm(m_st ^ SW'(d), 3);
            if (c == 2'b01) begin
`ifdef LOBY_STREAM_KEYFEED_EN
                s = s ^ m_key;
`endif
                m_dout = s;
            end
            m_st = s;
        end
    endtask

    // Wait for in_ready, present one command for one accepting edge, update the model.
    task automatic issue3(input logic [1:0] c, input logic [RT-1:0] d);
        int n = 0;
        while (ir3 !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) begin
            nchk++; nerr++;
            $display("FAIL issue_ready_timeout actual=%0d required=<50", n);
        end
        cmd3 = c; din3 = d; iv3 = 1'b1;
        @(posedge clk); #1;
        iv3 = 1'b0;
        model_cmd(c, d, key3);
    endtask

    task automatic wait_idle3(output int n);
        n = 0;
        while (ir3 !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    endtask

    task automatic wait_dv3(output int n);
        n = 0;
        while (dv3 !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [SW-1:0] cap;
        logic ok;
        iv3 = 0; dr3 = 0; cmd3 = 0; din3 = 0; key3 = '0;
        iv1 = 0; dr1 = 0; cmd1 = 0; din1 = 0; key1 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 arstn = 1'b1;
        @(posedge clk); #1;

        chki("rst_in_ready", int'(ir3), 1);
        chki("rst_dout_valid", int'(dv3), 0);
        chkw("rst_dout", dout3, '0);
        chki("rst_err", int'(err3), 0);
        chki("rst_busy", int'(busy3), 0);
        chki("rst_r1_ready", int'(ir1), 1);

        // ROUNDS=1: key^din clears the state, so the result is one round of zero.
        key1 = SW'(1);
        cmd1 = 2'b10; iv1 = 1'b1;
        @(posedge clk); #1;
        cmd1 = 2'b01; din1 = 64'h1; dr1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        chki("r1_dv_at_accept", int'(dv1), 0);
        @(posedge clk); #1;
        chki("r1_dv_1cyc", int'(dv1), 1);
        chki("r1_ready_in_out", int'(ir1), 0);
`ifdef LOBY_STREAM_KEYFEED_EN
        chkw("r1_dout", dout1, SW'(64'h9E37_79B9_7F4A_7C15) ^ key1);
`else
        chkw("r1_dout", dout1, SW'(64'h9E37_79B9_7F4A_7C15));
`endif
        @(posedge clk); #1;
        chki("r1_ready_2cyc", int'(ir1), 1);
        chki("r1_dv_pulse", int'(dv1), 0);
        dr1 = 1'b0;

        // Command table on ROUNDS=3: error flagging, clearing, and keyed absorb timing
        tbl[0] = '{"absorb_unkeyed", 2'b00, 1'b1, 1'b0};
        tbl[1] = '{"rsvd_a",         2'b11, 1'b1, 1'b0};
        tbl[2] = '{"init_a",         2'b10, 1'b0, 1'b0};
        tbl[3] = '{"rsvd_b",         2'b11, 1'b1, 1'b0};
        tbl[4] = '{"init_b",         2'b10, 1'b0, 1'b0};
        tbl[5] = '{"absorb_a",       2'b00, 1'b0, 1'b1};
        tbl[6] = '{"absorb_b",       2'b00, 1'b0, 1'b1};
        key3 = rand_w();
        for (int i = 0; i < 7; i++) begin
            issue3(tbl[i].cmd, {$urandom, $urandom});
            chki({tbl[i].nm, "_err"}, int'(err3), int'(tbl[i].exp_err));
            chki({tbl[i].nm, "_busy"}, int'(busy3), int'(tbl[i].exp_busy));
            if (tbl[i].exp_busy) begin
                wait_idle3(n);
                chki({tbl[i].nm, "_ready_low_cycles"}, n, 3);
            end
        end

        // Squeeze with consumer ready: registered valid after 3 cycles, single-cycle pulse
        dr3 = 1'b1;
        issue3(2'b01, {$urandom, $urandom});
        wait_dv3(n);
        chki("sqz_latency", n, 3);
        chkw("sqz_dout", dout3, m_dout);
        @(posedge clk); #1;
        chki("sqz_pulse_dv", int'(dv3), 0);
        chki("sqz_pulse_ready", int'(ir3), 1);

        // Back-pressure: hold in OUT for 10 cycles
        dr3 = 1'b0;
        issue3(2'b01, {$urandom, $urandom});
        wait_dv3(n);
        chki("bp_latency", n, 3);
        cap = dout3;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (dout3 !== cap || ir3 !== 1'b0 || busy3 !== 1'b1 || dv3 !== 1'b1) ok = 1'b0;
        end
        chki("bp_hold_stable", int'(ok), 1);
        chkw("bp_dout", dout3, m_dout);
        dr3 = 1'b1;
        @(posedge clk); #1;
        dr3 = 1'b0;
        chki("bp_release_dv", int'(dv3), 0);
        chki("bp_release_ready", int'(ir3), 1);
        chki("bp_release_busy", int'(busy3), 0);
        chkw("bp_dout_kept", dout3, m_dout);

        // Randomised command stream
        for (int it = 0; it < 30; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                key3 = rand_w();
                issue3(2'b10, '0);
            end else if (r == 1) begin
                issue3(2'b11, {$urandom, $urandom});
            end else if (r < 6) begin
                issue3(2'b00, {$urandom, $urandom});
                wait_idle3(n);
                chki("rnd_absorb_cycles", n, 3);
            end else begin
                issue3(2'b01, {$urandom, $urandom});
                wait_dv3(n);
                chki("rnd_sqz_latency", n, 3);
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                chkw("rnd_sqz_dout", dout3, m_dout);
                dr3 = 1'b1;
                @(posedge clk); #1;
                dr3 = 1'b0;
                chki("rnd_sqz_done", int'(dv3), 0);
            end
            chki("rnd_err", int'(err3), int'(m_err));
        end

        // Asynchronous reset in the second PERMUTE cycle of a squeeze
        key3 = rand_w();
        issue3(2'b10, '0);
        issue3(2'b01, {$urandom, $urandom});
        wait_dv3(n);
        dr3 = 1'b1;
        @(posedge clk); #1;
        dr3 = 1'b0;
        issue3(2'b01, {$urandom, $urandom});
        @(posedge clk); #1;
        #2 arstn = 1'b0;
        #1;
        model_reset();
        chki("arst_in_ready", int'(ir3), 1);
        chki("arst_busy", int'(busy3), 0);
        chki("arst_dv", int'(dv3), 0);
        chkw("arst_dout", dout3, m_dout);
        chki("arst_err", int'(err3), 0);
        @(posedge clk); #1;
        arstn = 1'b1;
        @(posedge clk); #1;
        issue3(2'b00, {$urandom, $urandom});
        chki("arst_unkeyed_err", int'(err3), int'(m_err));
        chki("arst_unkeyed_busy", int'(busy3), 0);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
